paddle_motion: RTL and testbench

- Parametrised paddle ("board") position engine for the breakout-style VGA game. It replaces the fixed board_x/board_y constants that currently feed the display.
- Takes debounced left/right levels and a once-per-frame tick. Produces the paddle's top-left x/y coordinates.
- Adds per-frame stepping, hold-to-accelerate, direction-reversal handling, pause, and a selectable edge mode: clamp or wrap.

---
 rtl/paddle_motion.sv | 140 ++++++++++++++
 tb/tb_paddle_motion.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/paddle_motion.sv
// Paddle x-position engine: per-frame stepping with hold-to-accelerate,
// reversal handling, pause, and clamp or wrap behaviour at the screen edges.
module paddle_motion #(
  parameter int SCREEN_W     = 640,
  parameter int PADDLE_W     = 64,
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int START_X      = 288,
  parameter int BOARD_Y      = 296,
  parameter int MIN_STEP     = 1,
  parameter int MAX_STEP     = 8,
  parameter int ACCEL_FRAMES = 4,
  parameter int WRAP         = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic           left,
  input  logic           right,
  input  logic           pause,
  output logic [X_W-1:0] board_x,
  output logic [Y_W-1:0] board_y,
  output logic [3:0]     speed,
  output logic [1:0]     moving,
  output logic           at_left,
  output logic           at_right,
  output logic           bump
);

  localparam int XMAX = SCREEN_W - PADDLE_W;
  localparam int HW   = $clog2(ACCEL_FRAMES + 2);

  typedef logic [X_W:0] xe_t;
  localparam xe_t          XMAX_E = xe_t'(XMAX);
  localparam xe_t          SPAN_E = xe_t'(XMAX + 1);
  localparam logic [3:0]   MIN4   = 4'(MIN_STEP);
  localparam logic [3:0]   MAX4   = 4'(MAX_STEP);
  localparam logic [HW:0]  ACC_E  = (HW+1)'(ACCEL_FRAMES);

  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

  state_t          r_state, w_state_nx, w_tgt;
  logic [X_W-1:0]  r_x, w_x_nx;
  logic [3:0]      r_speed, w_speed_nx, w_step;
  logic [HW-1:0]   r_hold, w_hold_nx;
  logic            r_at_l, r_at_r, r_bump, w_bump_nx, w_clamp, w_entry;
  xe_t             w_xe, w_stepe, w_dn, w_up, w_dn_wrap, w_up_wrap;
  logic [HW:0]     w_hold_p1;

  assign w_tgt     = (left & ~right) ? MOVE_L : ((right & ~left) ? MOVE_R : IDLE);
  assign w_entry   = (w_tgt != r_state);
  // A fresh direction always starts at the minimum step regardless of prior speed.
  assign w_step    = w_entry ? MIN4 : r_speed;
  assign w_xe      = {1'b0, r_x};
  assign w_stepe   = xe_t'(w_step);
  assign w_dn      = w_xe - w_stepe;
  assign w_up      = w_xe + w_stepe;
  assign w_dn_wrap = w_xe + SPAN_E - w_stepe;
  assign w_up_wrap = w_up - SPAN_E;
  assign w_hold_p1 = {1'b0, r_hold} + (HW+1)'(1);

  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_speed_nx = r_speed;
    w_hold_nx  = r_hold;
    w_bump_nx  = 1'b0;
    w_clamp    = 1'b0;
    if (frame_tick && !pause) begin
      if (w_tgt == IDLE) begin
        w_state_nx = IDLE;
        w_speed_nx = MIN4;
        w_hold_nx  = '0;
      end else begin
        w_state_nx = w_tgt;
        if (w_entry) begin
          w_speed_nx = MIN4;
          w_hold_nx  = HW'(1);
        end else if (w_hold_p1 >= ACC_E) begin
          // >= lets ACCEL_FRAMES == 1 accelerate right after the entry frame
          w_speed_nx = (r_speed >= MAX4) ? MAX4 : r_speed + 4'd1;
          w_hold_nx  = '0;
        end else begin
          w_hold_nx  = w_hold_p1[HW-1:0];
        end
        if (w_tgt == MOVE_L) begin
          if (w_xe < w_stepe) begin
            if (WRAP != 0) w_x_nx = w_dn_wrap[X_W-1:0];
            else begin
              w_x_nx  = '0;
              w_clamp = 1'b1;
            end
          end else w_x_nx = w_dn[X_W-1:0];
        end else begin
          if (w_up > XMAX_E) begin
            if (WRAP != 0) w_x_nx = w_up_wrap[X_W-1:0];
            else begin
              w_x_nx  = XMAX_E[X_W-1:0];
              w_clamp = 1'b1;
            end
          end else w_x_nx = w_up[X_W-1:0];
        end
        if (w_clamp) begin
          w_bump_nx  = 1'b1;
          w_speed_nx = MIN4;
          w_hold_nx  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= X_W'(START_X);
      r_speed <= MIN4;
      r_hold  <= '0;
      r_bump  <= 1'b0;
      r_at_l  <= (START_X == 0);
      r_at_r  <= (START_X == XMAX);
    end else begin
      r_state <= w_state_nx;
      r_x     <= w_x_nx;
      r_speed <= w_speed_nx;
      r_hold  <= w_hold_nx;
      r_bump  <= w_bump_nx;
      r_at_l  <= (w_x_nx == '0);
      r_at_r  <= ({1'b0, w_x_nx} == XMAX_E);
    end
  end

  assign board_x  = r_x;
  assign board_y  = Y_W'(BOARD_Y);
  assign speed    = r_speed;
  assign moving   = {r_state == MOVE_L, r_state == MOVE_R};
  assign at_left  = r_at_l;
  assign at_right = r_at_r;
  assign bump     = r_bump;

endmodule

// File: tb/tb_paddle_motion.sv
// Bench for paddle_motion: three configurations (default clamp, clamp near
// the left edge, wrap near the right edge) against an arithmetic model.
module tb_paddle_motion;

  localparam int XMAX = 576;
  localparam int MINS = 1;
  localparam int MAXS = 8;
  localparam int ACC  = 4;

  logic       clk = 1'b0;
  logic       rst, tk, pa;
  logic [2:0] l, r;
  logic [9:0] bx [3];
  logic [9:0] by [3];
  logic [3:0] sp [3];
  logic [1:0] mv [3];
  logic       al [3];
  logic       ar [3];
  logic       bp [3];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  paddle_motion u_def (
    .clk(clk), .rst(rst), .frame_tick(tk), .left(l[0]), .right(r[0]), .pause(pa),
    .board_x(bx[0]), .board_y(by[0]), .speed(sp[0]), .moving(mv[0]),
    .at_left(al[0]), .at_right(ar[0]), .bump(bp[0]));

  paddle_motion #(.START_X(3)) u_lft (
    .clk(clk), .rst(rst), .frame_tick(tk), .left(l[1]), .right(r[1]), .pause(pa),
    .board_x(bx[1]), .board_y(by[1]), .speed(sp[1]), .moving(mv[1]),
    .at_left(al[1]), .at_right(ar[1]), .bump(bp[1]));

  paddle_motion #(.START_X(574), .WRAP(1)) u_wrp (
    .clk(clk), .rst(rst), .frame_tick(tk), .left(l[2]), .right(r[2]), .pause(pa),
    .board_x(bx[2]), .board_y(by[2]), .speed(sp[2]), .moving(mv[2]),
    .at_left(al[2]), .at_right(ar[2]), .bump(bp[2]));

  typedef struct {
    int x;
    int spd;
    int hold;
    int dir;   // -1 left, +1 right, 0 idle
    bit bump;
  } m_t;

  m_t m [3];
  int sx [3] = '{288, 3, 574};
  int wr [3] = '{0, 0, 1};

  function automatic m_t mstep(m_t s, int startx, int wrap, bit li, bit ri, bit rs, bit t, bit p);
    int req, st, nx;
    m_t n = s;
    n.bump = 1'b0;
    if (rs) begin
      n.x = startx; n.spd = MINS; n.hold = 0; n.dir = 0;
    end else if (t && !p) begin
      req = (li && !ri) ? -1 : ((ri && !li) ? 1 : 0);
      if (req == 0) begin
        n.dir = 0; n.spd = MINS; n.hold = 0;
      end else begin
        if (req != s.dir) begin
          st = MINS; n.spd = MINS; n.hold = 1;
        end else begin
          st = s.spd;
          if (s.hold + 1 >= ACC) begin
            n.spd = (s.spd + 1 > MAXS) ? MAXS : s.spd + 1;
            n.hold = 0;
          end else n.hold = s.hold + 1;
        end
        n.dir = req;
        nx = s.x + req * st;
        if (nx < 0 || nx > XMAX) begin
          if (wrap != 0) nx = (nx < 0) ? nx + XMAX + 1 : nx - (XMAX + 1);
          else begin
            nx = (nx < 0) ? 0 : XMAX;
            n.bump = 1'b1; n.spd = MINS; n.hold = 0;
          end
        end
        n.x = nx;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input int i);
    logic [1:0] emv;
    emv = (m[i].dir < 0) ? 2'b10 : ((m[i].dir > 0) ? 2'b01 : 2'b00);
    chk($sformatf("u%0d.board_x", i), 32'(bx[i]), 32'(m[i].x));
    chk($sformatf("u%0d.board_y", i), 32'(by[i]), 32'd296);
    chk($sformatf("u%0d.speed", i),   32'(sp[i]), 32'(m[i].spd));
    chk($sformatf("u%0d.moving", i),  32'(mv[i]), 32'(emv));
    chk($sformatf("u%0d.at_left", i), 32'(al[i]), 32'(m[i].x == 0));
    chk($sformatf("u%0d.at_right", i),32'(ar[i]), 32'(m[i].x == XMAX));
    chk($sformatf("u%0d.bump", i),    32'(bp[i]), 32'(m[i].bump));
  endtask

  task automatic cyc(input logic [2:0] li, input logic [2:0] ri, input logic t, input logic p, input logic rs);
    l = li; r = ri; tk = t; pa = p; rst = rs;
    @(posedge clk);
    for (int i = 0; i < 3; i++) m[i] = mstep(m[i], sx[i], wr[i], li[i], ri[i], rs, t, p);
    #1;
    for (int i = 0; i < 3; i++) chk_model(i);
  endtask

  initial begin
    int e0 [6] = '{289, 290, 291, 292, 294, 296};
    int e1 [4] = '{2, 1, 0, 0};
    int b1 [4] = '{0, 0, 0, 1};
    int e2 [3] = '{575, 576, 0};
    logic [2:0] pl, pr, li, ri;
    int len;

    for (int i = 0; i < 3; i++) m[i] = '{x: 0, spd: 0, hold: 0, dir: 0, bump: 1'b0};
    l = '0; r = '0; tk = 1'b0; pa = 1'b0; rst = 1'b1;
    #1;
    // Reset with a coincident tick and left held must be ignored
    cyc(3'b111, 3'b000, 1'b1, 1'b0, 1'b1);
    cyc(3'b111, 3'b000, 1'b1, 1'b0, 1'b1);
    chk("rst.board_x", 32'(bx[0]), 32'd288);
    chk("rst.speed", 32'(sp[0]), 32'd1);
    chk("rst.moving", 32'(mv[0]), 32'd0);
    chk("rst.at_l_r", 32'({al[0], ar[0]}), 32'd0);
    cyc(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      cyc(3'b010, 3'b101, 1'b1, 1'b0, 1'b0);
      chk($sformatf("hold_r.x%0d", k), 32'(bx[0]), 32'(e0[k]));
      chk($sformatf("left_edge.x%0d", k), 32'(bx[1]), 32'(e1[k]));
      chk($sformatf("left_edge.bump%0d", k), 32'(bp[1]), 32'(b1[k]));
      if (k < 3) chk($sformatf("wrap.x%0d", k), 32'(bx[2]), 32'(e2[k]));
    end
    chk("hold_r.speed", 32'(sp[0]), 32'd2);
    chk("hold_r.moving", 32'(mv[0]), 32'd1);
    cyc(3'b010, 3'b101, 1'b0, 1'b0, 1'b0);
    chk("left_edge.bump_drop", 32'(bp[1]), 32'd0);
    chk("left_edge.at_left", 32'(al[1]), 32'd1);
    chk("left_edge.speed", 32'(sp[1]), 32'd1);
    for (int k = 4; k < 6; k++) begin
      cyc(3'b000, 3'b001, 1'b1, 1'b0, 1'b0);
      chk($sformatf("hold_r.x%0d", k), 32'(bx[0]), 32'(e0[k]));
    end

    cyc(3'b000, 3'b001, 1'b1, 1'b0, 1'b0);
    cyc(3'b000, 3'b001, 1'b1, 1'b0, 1'b0);
    chk("accel.speed3", 32'(sp[0]), 32'd3);
    chk("accel.x", 32'(bx[0]), 32'd300);
    cyc(3'b001, 3'b001, 1'b1, 1'b0, 1'b0);
    chk("both.x", 32'(bx[0]), 32'd300);
    chk("both.moving", 32'(mv[0]), 32'd0);
    chk("both.speed", 32'(sp[0]), 32'd1);
    cyc(3'b001, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("rev.x", 32'(bx[0]), 32'd299);
    chk("rev.moving", 32'(mv[0]), 32'd2);

    for (int k = 0; k < 4; k++) cyc(3'b000, 3'b001, 1'b1, 1'b0, 1'b0);
    chk("pause.pre_x", 32'(bx[0]), 32'd303);
    chk("pause.pre_speed", 32'(sp[0]), 32'd2);
    for (int k = 0; k < 10; k++) cyc(3'b000, 3'b001, 1'b1, 1'b1, 1'b0);
    chk("pause.frozen_x", 32'(bx[0]), 32'd303);
    chk("pause.frozen_speed", 32'(sp[0]), 32'd2);
    cyc(3'b000, 3'b001, 1'b1, 1'b0, 1'b0);
    chk("pause.resume_x", 32'(bx[0]), 32'd305);

    // Long direction runs so both edges and the speed ceiling are reached
    for (int c = 0; c < 250; c++) begin
      pl = 3'($urandom); pr = 3'($urandom);
      len = $urandom_range(1, 60);
      for (int j = 0; j < len; j++) begin
        li = pl; ri = pr;
        if ($urandom_range(0, 15) == 0) li = li ^ 3'($urandom);
        if ($urandom_range(0, 15) == 0) ri = ri ^ 3'($urandom);
        cyc(li, ri, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 499) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
